// File: rtl/data_upload.sv
// SPI client that uploads a file from core RAM to the io controller; reverse of the download block.
// Optional XOR checksum readback (command 8'h58) is enabled by defining DATA_UPLOAD_CSUM_EN.
`timescale 1ns/1ps

module data_upload #(
    parameter logic [24:0] BASE_ROM  = 25'h170000,
    parameter logic [24:0] BASE_TRD  = 25'h200000,
    parameter logic [24:0] BASE_TAPE = 25'h400000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sck,
    input  logic        ss,
    input  logic        sdi,
    output logic        sdo,
    input  logic [4:0]  index,
    output logic        uploading,
    output logic        underrun,
    output logic        rd,
    output logic [24:0] addr,
    input  logic [7:0]  din,
    input  logic        ack
);

    localparam logic [7:0] UIO_FILE_RX     = 8'h56;
    localparam logic [7:0] UIO_FILE_RX_DAT = 8'h57;

    logic [1:0]  sck_sync, ss_sync, sdi_sync;
    logic        sck_d;
    logic        sck_s, ss_s, sdi_s, sck_rise, sck_fall;

    logic [3:0]  cnt;
    logic [6:0]  sbuf;
    logic [7:0]  cmd;
    logic [7:0]  sreg;
    logic [7:0]  buffer;
    logic        valid, pending, stale;
    logic [24:0] base;
    logic        start_evt, file_start, file_end;
    logic        load_evt, data_load, csum_load, tx_cmd, ack_take;
    logic [7:0]  load_byte;

    // NOTE: every sequential block uses non-blocking assignments so each flop samples the
    // previous-cycle value of its neighbours; the sync chains and shift registers depend on it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync <= '0;
            ss_sync  <= '0;
            sdi_sync <= '0;
            sck_d    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], sck};
            ss_sync  <= {ss_sync[0], ss};
            sdi_sync <= {sdi_sync[0], sdi};
            sck_d    <= sck_sync[1];
        end
    end

    assign sck_s    = sck_sync[1];
    assign ss_s     = ss_sync[1];
    assign sdi_s    = sdi_sync[1];
    assign sck_rise = sck_s && !sck_d;
    assign sck_fall = !sck_s && sck_d;

    always_comb begin
        base = BASE_ROM;
        case (index)
            5'd1:    base = BASE_TRD;
            5'd2:    base = BASE_TAPE;
            default: base = BASE_ROM;
        endcase
    end

    assign start_evt  = sck_rise && !ss_s && (cnt == 4'd15) && (cmd == UIO_FILE_RX);
    assign file_start = start_evt && sdi_s;
    assign file_end   = start_evt && !sdi_s;
    assign load_evt   = sck_fall && !ss_s && (cnt == 4'd8);
    assign data_load  = load_evt && (cmd == UIO_FILE_RX_DAT);
    assign ack_take   = ack && pending;

`ifdef DATA_UPLOAD_CSUM_EN
    localparam logic [7:0] UIO_FILE_CSUM = 8'h58;
    logic [7:0] csum;

    assign csum_load = load_evt && (cmd == UIO_FILE_CSUM);
    assign tx_cmd    = (cmd == UIO_FILE_RX_DAT) || (cmd == UIO_FILE_CSUM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            csum <= 8'h00;
        else if (file_start)
            csum <= 8'h00;
        else if (data_load)
            csum <= csum ^ load_byte;
    end

    always_comb begin
        load_byte = valid ? buffer : 8'h00;
        if (csum_load)
            load_byte = csum;
    end
`else
    assign csum_load = 1'b0;
    assign tx_cmd    = (cmd == UIO_FILE_RX_DAT);

    always_comb begin
        load_byte = valid ? buffer : 8'h00;
    end
`endif

    // SPI side: bit counter, command capture and the outgoing shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= 4'd0;
            sbuf <= 7'd0;
            cmd  <= 8'h00;
            sreg <= 8'h00;
        end else if (ss_s) begin
            cnt  <= 4'd0;
            sbuf <= 7'd0;
            sreg <= 8'h00;
        end else begin
            if (sck_rise) begin
                sbuf <= {sbuf[5:0], sdi_s};
                cnt  <= (cnt == 4'd15) ? 4'd8 : cnt + 4'd1;
                if (cnt == 4'd7)
                    cmd <= {sbuf, sdi_s};
            end
            if (sck_fall) begin
                if (data_load || csum_load)
                    sreg <= load_byte;
                else
                    sreg <= {sreg[6:0], 1'b0};
            end
        end
    end

    assign sdo = tx_cmd && sreg[7];

    // RAM side: one outstanding read; an ack for a read issued before a start/end is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd        <= 1'b0;
            addr      <= 25'd0;
            buffer    <= 8'h00;
            valid     <= 1'b0;
            pending   <= 1'b0;
            stale     <= 1'b0;
            uploading <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            rd <= 1'b0;
            if (ack_take) begin
                pending <= 1'b0;
                stale   <= 1'b0;
                if (uploading && !stale) begin
                    buffer <= din;
                    valid  <= 1'b1;
                    addr   <= addr + 25'd1;
                end
            end else if (uploading && !valid && !pending && !start_evt) begin
                rd      <= 1'b1;
                pending <= 1'b1;
            end

            // The load sees the pre-ack valid, so a same-cycle ack survives for the next load.
            if (data_load) begin
                if (valid)
                    valid <= 1'b0;
                else
                    underrun <= 1'b1;
            end

            if (file_start) begin
                addr      <= base;
                valid     <= 1'b0;
                underrun  <= 1'b0;
                uploading <= 1'b1;
                stale     <= pending && !ack_take;
            end
            if (file_end) begin
                uploading <= 1'b0;
                stale     <= pending && !ack_take;
            end
        end
    end

endmodule

// File: doc/data_upload.md
Name: data_upload

Overview:
- SPI client for file upload from core RAM to the io controller. It is the reverse path of the existing download block.
- Listens on the shared io-controller SPI bus, which it oversamples in the core clock domain.
- Answers the file-receive command set. Prefetches bytes from external RAM through a rd/ack handshake and shifts them out MSB-first on sdo.
- Sits beside the download block and shares sck/ss/sdi and the menu index. Used for saving tape and TRD images.

Parameters:
- BASE_ROM, 25'h170000, upload base address for index 0 and any unlisted index.
- BASE_TRD, 25'h200000, upload base address for index 1.
- BASE_TAPE, 25'h400000, upload base address for index 2.

Ports:
- clk  in  1  core clock; must be at least 4x the sck frequency.
- reset  in  1  asynchronous, active-high reset.
- sck  in  1  SPI clock from io controller, asynchronous.
- ss  in  1  SPI select, active-high deselect, asynchronous.
- sdi  in  1  SPI data from io controller, asynchronous.
- sdo  out  1  SPI data to io controller.
- index  in  5  menu index latched by the download block.
- uploading  out  1  upload session active.
- underrun  out  1  sticky flag: a byte was needed before RAM returned it.
- rd  out  1  RAM read request, one-cycle pulse.
- addr  out  25  RAM read address, stable from rd until ack.
- din  in  8  RAM read data, valid in the ack cycle.
- ack  in  1  RAM read completion, one cycle.

Behaviour:
- Reset values: sdo=0, uploading=0, underrun=0, rd=0, addr=0. Internal state also clears: cnt=0, cmd=0, buffer valid=0, read pending=0.
- Synchronisation: sck, ss, sdi each pass through 2 flops. Rise and fall of sck are detected from the synchronised copy. Edge-to-action latency is 3 clk.
- Synchronised ss=1: cnt=0 and the shift register is cleared. The buffer, addr and uploading are kept. A byte is consumed only when it is loaded.
- sck rise, ss=0:
  - Shift sdi into sbuf[6:0].
  - cnt sequence is 0..7, then 8..15 repeating. 15 wraps to 8.
  - At cnt==7: cmd <= {sbuf, sdi}.
- Command UIO_FILE_RX 8'h56, evaluated at cnt==15 using sdi:
  - sdi=1 (start): addr <= base selected by index; valid=0; underrun=0; uploading=1.
  - sdi=0 (end): uploading=0. A pending read still completes on ack, and its data is discarded.
- Command UIO_FILE_RX_DAT 8'h57, on the sck fall when cnt==8 (first fall after bit 7 or bit 15):
  - valid=1: shift register <= buffer; valid<=0.
  - valid=0: shift register <= 8'h00; underrun<=1.
  - sdo = shift register bit 7.
  - Each following fall in the byte shifts left by one; sdo = new bit 7.
- Other commands: sdo is held at 0.
- Prefetch: when uploading && !valid && !pending, pulse rd for 1 clk and set pending=1.
- On ack: buffer<=din, valid<=1, pending<=0, addr<=addr+1. While uploading=0 only pending is cleared.
- Only one read is outstanding at a time. A start command issued while a read is pending waits for that ack, then re-requests from the new base.
- Simultaneous ack and load in the same clk: the load takes the old buffer state. If valid was 0 the byte goes out as 8'h00 and the acked byte is kept for the next load.
- addr arithmetic: 25-bit and wraps silently at 25'h1FFFFFF.
- Reset mid-transfer: everything returns to reset values immediately. An ack arriving later is ignored because pending=0.

Optional Feature:
- Macro DATA_UPLOAD_CSUM_EN.
- Defined:
  - An 8-bit XOR checksum accumulates every byte loaded for transmission, including underrun zeros. It is cleared by a start command.
  - Command 8'h58: the checksum is loaded on the cnt==8 fall and shifted out the same way as data.
  - RAM is not read and the buffer is not consumed.
- Not defined: 8'h58 is treated as an unknown command and sdo stays 0.

Test Plan:
- Reset, then cmd 8'h56 with data byte 8'h01 and index=2 -> uploading=1; rd pulse with addr=25'h400000 within 4 clk of the final sck rise.
- RAM returns 8'hA5, 8'h3C with ack latency 2 clk; cmd 8'h57 then 2 data bytes -> sdo sampled on sck rises reads 10100101, 00111100; addr ends at 25'h400002; underrun=0.
- ack latency set to 200 clk, sck = clk/8 -> second byte reads 8'h00; underrun=1; the next byte after the data returns is correct.
- ss deasserted after 3 bits of a data byte, then reselect and repeat 8'h57 -> the interrupted byte is not resent; the next byte comes from the buffer; addr advances by 1 per loaded byte only.
- cmd 8'h56 with 8'h00 while a read is pending, then ack -> uploading=0; no further rd pulses; buffer unchanged.
- DATA_UPLOAD_CSUM_EN defined: upload 8'hA5, 8'h3C, then cmd 8'h58 -> sdo shifts out 8'h99; no rd pulse issued.
